seg7_scan_driver: RTL

Parametrised, time-multiplexed hex 7-segment display driver: the multi-digit successor to our single-digit hex-to-7-segment decoders. Captures an NDIG-nibble value on a load strobe and scans one digit at a time onto a shared segment bus with per-digit select. Adds digit enables, leading-zero blanking, per-digit blink and decimal points. Sits between user logic (counters, debug registers) and the board's segment/anode pins.

---
 rtl/seg7_scan_driver.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment driver: captures an NDIG-nibble value on load
// and scans one digit per SCAN_DIV cycles with enables, blink, dp and zero blanking.
module seg7_scan_driver #(
  parameter int NDIG       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] data,
  input  logic              load,
  input  logic [NDIG-1:0]   dp,
  input  logic [NDIG-1:0]   blink,
  input  logic [NDIG-1:0]   en,
  input  logic              blank_lz,
  output logic [6:0]        seg,
  output logic              seg_dp,
  output logic [NDIG-1:0]   an
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  // XOR mask turning active-high internal levels into pin levels.
  localparam logic POL = ACTIVE_LOW;

  logic [4*NDIG-1:0] data_sh;
  logic [NDIG-1:0]   dp_sh;
  logic [NDIG-1:0]   blink_sh;
  logic [IW-1:0]     idx;
  logic [SW-1:0]     scan_cnt;
  logic [BW-1:0]     blink_cnt;
  logic              phase;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    unique case (nib)
      4'h0: glyph = 7'b1111110;
      4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;
      4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;
      4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;
      4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1111011;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b0011111;
      4'hC: glyph = 7'b1001110;
      4'hD: glyph = 7'b0111101;
      4'hE: glyph = 7'b1001111;
      default: glyph = 7'b1000111;
    endcase
  endfunction

  // NOTE: the shadow registers are a handful of flops, not a RAM, so they take
  // the async reset like every other piece of state here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sh  <= '0;
      dp_sh    <= '0;
      blink_sh <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignments for every flop, so all registers update
      // from pre-edge values regardless of block order.
      data_sh  <= data;
      dp_sh    <= dp;
      blink_sh <= blink;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Free-running blink timebase, deliberately unrelated to the scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  logic [3:0]      nib [NDIG];
  logic [NDIG-1:0] lz;
  logic            zero_above;
  logic            dark;
  logic [6:0]      seg_h;
  logic            dp_h;
  logic [NDIG-1:0] an_h;

  // lz[i] is set when nibbles i..NDIG-1 of the shadow are all zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    zero_above = 1'b1;
    lz         = '0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      nib[k]     = data_sh[4*k +: 4];
      zero_above = zero_above & (nib[k] == 4'h0);
      lz[k]      = zero_above;
    end
  end

  always_comb begin
    dark  = !en[idx] || (blink_sh[idx] && phase) ||
            (blank_lz && lz[idx] && (idx != '0));
    seg_h = '0;
    dp_h  = 1'b0;
    an_h  = '0;
    if (!dark) begin
      seg_h     = glyph(nib[idx]);
      dp_h      = dp_sh[idx];
      an_h[idx] = 1'b1;
    end
  end

  // Registered outputs: a new index shows up on the pins one cycle later, alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg    <= {7{POL}};
      seg_dp <= POL;
      an     <= {NDIG{POL}};
    end else begin
      seg    <= seg_h ^ {7{POL}};
      seg_dp <= dp_h ^ POL;
      an     <= an_h ^ {NDIG{POL}};
    end
  end

endmodule
